idct_1d_8x8_seq: RTL and testbench

//   Inverse 1-D DCT over an 8x8 block: f(r,x) = sum_u c(u,x)*F(r,u) per row r.

---
 rtl/idct_1d_8x8_seq_pkg.sv | 19 +
 rtl/idct_1d_8x8_seq_mac_lane.sv | 70 +++++++
 rtl/idct_1d_8x8_seq.sv | 130 +++++++++++++
 tb/tb_idct_1d_8x8_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_1d_8x8_seq_pkg.sv
// Shared constants, FSM encoding and index helper for the 8x8 row IDCT engine.
package idct_1d_8x8_seq_pkg;

   localparam int unsigned DCT_N     = 8;
   localparam int unsigned DCT_BLK   = DCT_N * DCT_N;
   localparam int unsigned DCT_LOG2N = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_COMP = 2'd1,
      ST_DONE = 2'd2
   } dct_state_e;

   // Flat index of element (row, col) in a row-major 8x8 block.
   function automatic int unsigned blk_idx(input int unsigned row, input int unsigned col);
      return row * DCT_N + col;
   endfunction

endpackage

// File: rtl/idct_1d_8x8_seq_mac_lane.sv
// One IDCT output lane: signed MAC, wide accumulator and round/narrow stage.
// IDCT_SAT_EN selects clamping narrowing; otherwise two's-complement truncation.
module idct_1d_8x8_seq_mac_lane #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en_i,
   input  logic                  last_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] res_o_c,
   output logic                  sat_o_c
);

   localparam int unsigned PW = 2 * DATA_WIDTH;
   localparam int unsigned AW = 2 * DATA_WIDTH + 3;
   localparam logic signed [AW-1:0] HALF =
      {{(AW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

   logic signed [PW-1:0] prod_c;
   logic signed [AW-1:0] acc_q, acc_d;
   logic signed [AW-1:0] sum_c, rnd_c;

   assign prod_c = PW'($signed(a_i)) * PW'($signed(b_i));
   assign sum_c  = acc_q + AW'(prod_c);
   assign rnd_c  = sum_c + HALF;

`ifdef IDCT_SAT_EN
   localparam logic signed [AW-1:0] MAX_V = AW'({1'b0, {(DATA_WIDTH-1){1'b1}}});
   localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

   logic signed [AW-1:0] shr_c;

   // Clamp the rounded row sum into the signed output range.
   always_comb begin
      shr_c   = rnd_c >>> FRAC_BITS;
      res_o_c = DATA_WIDTH'(shr_c);
      sat_o_c = 1'b0;
      if (shr_c > MAX_V) begin
         res_o_c = MAX_V[DATA_WIDTH-1:0];
         sat_o_c = 1'b1;
      end else if (shr_c < MIN_V) begin
         res_o_c = MIN_V[DATA_WIDTH-1:0];
         sat_o_c = 1'b1;
      end
   end
`else
   assign res_o_c = DATA_WIDTH'(rnd_c >>> FRAC_BITS);
   assign sat_o_c = 1'b0;
`endif

   // Accumulate across taps; the last tap hands the sum to the narrowing stage and restarts.
   always_comb begin
      acc_d = acc_q;
      if (en_i) begin
         acc_d = last_i ? '0 : sum_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/idct_1d_8x8_seq.sv
// Sequential 1-D inverse DCT over an 8x8 block: 8 MAC lanes, one row per 8 cycles.
// Build option IDCT_SAT_EN enables output clamping and the sat_flag report.
module idct_1d_8x8_seq
   import idct_1d_8x8_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FRAC_BITS  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_WIDTH*DCT_BLK-1:0] coef_in,
   input  logic [DATA_WIDTH*DCT_BLK-1:0] coeff_vector,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH*DCT_BLK-1:0] pix_out,
   output logic                          sat_flag
);

   localparam int unsigned CW = $clog2(DCT_BLK);
   localparam int unsigned TW = DCT_LOG2N;

   dct_state_e state_q, state_d;

   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          in_ready_q, in_ready_d;
   logic                          out_valid_q, out_valid_d;
   logic                          sat_q, sat_d;
   logic [DATA_WIDTH*DCT_BLK-1:0] coef_q, mat_q, pix_q;

   logic [TW-1:0] row_c, tap_c;
   logic          accept_c, row_end_c, comp_c;
   logic [DATA_WIDTH-1:0]             a_c;
   logic [DCT_N-1:0][DATA_WIDTH-1:0]  lane_res;
   logic [DCT_N-1:0]                  lane_sat;

   assign row_c     = cnt_q[CW-1:TW];
   assign tap_c     = cnt_q[TW-1:0];
   assign comp_c    = (state_q == ST_COMP);
   assign accept_c  = in_valid && in_ready_q;
   assign row_end_c = comp_c && (tap_c == TW'(DCT_N - 1));

   // F(r,k) is broadcast to all lanes; lane x picks matrix entry c(k,x).
   assign a_c = coef_q[blk_idx(32'(row_c), 32'(tap_c))*DATA_WIDTH +: DATA_WIDTH];

   for (genvar x = 0; x < DCT_N; x++) begin : g_lane
      idct_1d_8x8_seq_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .en_i    (comp_c),
         .last_i  (row_end_c),
         .a_i     (a_c),
         .b_i     (mat_q[blk_idx(32'(tap_c), x)*DATA_WIDTH +: DATA_WIDTH]),
         .res_o_c (lane_res[x]),
         .sat_o_c (lane_sat[x])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept_c)                     state_d = ST_COMP;
         ST_COMP: if (cnt_q == CW'(DCT_BLK - 1))    state_d = ST_DONE;
         ST_DONE: if (out_ready)                    state_d = ST_IDLE;
         default:                                   state_d = ST_IDLE;
      endcase
   end

   // Handshake flags follow the next state so they are registered but never lag it.
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      if (accept_c) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end
      if (comp_c) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (row_end_c) begin
         sat_d = sat_q | (|lane_sat);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         coef_q      <= '0;
         mat_q       <= '0;
         pix_q       <= '0;
      end else begin
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
         if (accept_c) begin
            coef_q <= coef_in;
            mat_q  <= coeff_vector;
         end
         if (row_end_c) begin
            for (int x = 0; x < DCT_N; x++) begin
               pix_q[blk_idx(32'(row_c), x)*DATA_WIDTH +: DATA_WIDTH] <= lane_res[x];
            end
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign pix_out   = pix_q;
   assign sat_flag  = sat_q;

endmodule

// File: tb/tb_idct_1d_8x8_seq.sv
// Self-checking bench for idct_1d_8x8_seq: matrix-product reference model plus directed cases.
`timescale 1ns/1ps
module tb_idct_1d_8x8_seq;

   localparam int unsigned W   = 32;
   localparam int unsigned N   = 8;
   localparam int unsigned BLK = 64;
   localparam int unsigned BW  = W * BLK;

   typedef logic [BW-1:0] blk_t;
   typedef struct {
      blk_t pix;
      bit   sat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, out_valid, sat_flag;
   blk_t coef_in = '0;
   blk_t coeff_vector = '0;
   blk_t pix_out;

   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   int   cyc = 0;
   int   acc_cyc = 0;
   int   last_acc = -1;
   bit   inflight = 1'b0;
   bit   chk_en = 1'b0;
   bit   chain_chk = 1'b0;
   int   or_mode = 2;

   always #5 clk = ~clk;

   idct_1d_8x8_seq dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .coef_in      (coef_in),
      .coeff_vector (coeff_vector),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .pix_out      (pix_out),
      .sat_flag     (sat_flag)
   );

   // f(r,x) = round(sum_k F(r,k)*c(k,x) / 2^16), then narrowed to 32 bits.
   function automatic exp_t model(input blk_t f, input blk_t c);
      exp_t e;
      logic signed [95:0] s;
      e.sat = 1'b0;
      e.pix = '0;
      for (int r = 0; r < N; r++) begin
         for (int x = 0; x < N; x++) begin
            s = '0;
            for (int k = 0; k < N; k++)
               s = s + $signed(f[(r*N+k)*W +: W]) * $signed(c[(k*N+x)*W +: W]);
            s = (s + 96'sd32768) >>> 16;
`ifdef IDCT_SAT_EN
            if (s > 96'sh7FFFFFFF) begin
               s = 96'sh7FFFFFFF;
               e.sat = 1'b1;
            end else if (s < -96'sh80000000) begin
               s = -96'sh80000000;
               e.sat = 1'b1;
            end
`endif
            e.pix[(r*N+x)*W +: W] = s[W-1:0];
         end
      end
      return e;
   endfunction

   task automatic chk1(input string nm, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %b want %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic blk_chk(input string nm, input blk_t act, input blk_t exp);
      int bad;
      bad = -1;
      tests++;
      for (int i = BLK - 1; i >= 0; i--)
         if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s word %0d got %h want %h (t=%0t)", nm, bad,
                  act[bad*W +: W], exp[bad*W +: W], $time);
      end
   endtask

   // Handshake monitor: push the model result on accept, retire it on release.
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         exp_q.delete();
         inflight = 1'b0;
      end else begin
         if (out_valid && out_ready && inflight) begin
            void'(exp_q.pop_front());
            inflight = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(coef_in, coeff_vector));
            acc_cyc  = cyc;
            inflight = 1'b1;
            if (chain_chk && last_acc >= 0) chk32("accept_period", 32'(cyc - last_acc), 32'd66);
            last_acc = cyc;
         end
      end
   end

   // Compare process: handshake flags every cycle, block contents whenever valid.
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         chk1("in_ready", in_ready, !inflight);
         chk1("out_valid", out_valid, inflight && (cyc - acc_cyc >= 64));
         if (out_valid && inflight && exp_q.size() > 0) begin
            blk_chk("pix_out", pix_out, exp_q[0].pix);
            chk1("sat_flag", sat_flag, exp_q[0].sat);
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         out_ready = (or_mode == 0) ? 1'b1 :
                     (or_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input blk_t f, input blk_t c, input bit keep);
      int n;
      n = 0;
      coef_in = f;
      coeff_vector = c;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         tests++;
         fails++;
         $display("FAIL send_timeout in_ready stuck at %b", in_ready);
      end
      @(negedge clk);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_ov(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((inflight || in_ready !== 1'b1) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         tests++;
         fails++;
         $display("FAIL wait_done_timeout inflight %b in_ready %b", inflight, in_ready);
      end
   endtask

   function automatic blk_t rnd_blk(input int mode, input bit is_mat);
      blk_t b;
      logic [31:0] w;
      for (int i = 0; i < BLK; i++) begin
         w = $urandom;
         if (mode == 0) w = is_mat ? {{15{w[16]}}, w[16:0]} : {{12{w[20]}}, w[19:0]};
         b[i*W +: W] = w;
      end
      return b;
   endfunction

   blk_t f, c, lit;
   exp_t e;
   int   lat;
   real  v, a;
   logic [31:0] wv, exp3;

   initial begin
      repeat (3) @(negedge clk);
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      blk_chk("rst_pix_out", pix_out, '0);
      chk1("rst_sat_flag", sat_flag, 1'b0);
      reset = 1'b0;
      chk_en = 1'b1;
      or_mode = 2;
      @(negedge clk);

      // Identity matrix returns the coefficients unchanged.
      c = '0;
      for (int i = 0; i < BLK; i++) f[i*W +: W] = 32'(i - 32);
      for (int i = 0; i < N; i++) c[(i*N+i)*W +: W] = 32'h0001_0000;
      send(f, c, 1'b0);
      wait_ov(lat);
      chk32("t1_latency", 32'(lat), 32'd64);
      blk_chk("t1_pix", pix_out, f);
      chk1("t1_sat", sat_flag, 1'b0);
      or_mode = 0;
      wait_done();

      // Real DCT basis, DC-only row 0: flat row of ~1.0, other rows zero.
      for (int u = 0; u < N; u++)
         for (int x = 0; x < N; x++) begin
            a = (u == 0) ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0);
            v = a * $cos((2.0 * x + 1.0) * u * 3.14159265358979 / 16.0) * 65536.0;
            c[(u*N+x)*W +: W] = 32'((v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5));
         end
      f = '0;
      f[31:0] = 32'h0002_D414;
      or_mode = 2;
      send(f, c, 1'b0);
      wait_ov(lat);
      for (int i = 0; i < BLK; i++) begin
         wv = pix_out[i*W +: W];
         tests++;
         if (i < N) begin
            if (wv < 32'h0000_FFFF || wv > 32'h0001_0001) begin
               fails++;
               $display("FAIL t2_row0 x=%0d got %h want 00010000+/-1", i, wv);
            end
         end else if (wv !== 32'h0) begin
            fails++;
            $display("FAIL t2_rows1to7 idx=%0d got %h want 00000000", i, wv);
         end
      end
      or_mode = 0;
      wait_done();

      // Diagonal 2.0 on full-scale coefficients: overflow on narrowing.
      c = '0;
      for (int i = 0; i < BLK; i++) f[i*W +: W] = 32'h7FFF_FFFF;
      for (int i = 0; i < N; i++) c[(i*N+i)*W +: W] = 32'h0002_0000;
`ifdef IDCT_SAT_EN
      exp3 = 32'h7FFF_FFFF;
`else
      exp3 = 32'hFFFF_FFFE;
`endif
      for (int i = 0; i < BLK; i++) lit[i*W +: W] = exp3;
      e = model(f, c);
      blk_chk("t3_model", e.pix, lit);
      or_mode = 2;
      send(f, c, 1'b0);
      wait_ov(lat);
      blk_chk("t3_pix", pix_out, lit);
`ifdef IDCT_SAT_EN
      chk1("t3_sat", sat_flag, 1'b1);
`else
      chk1("t3_sat", sat_flag, 1'b0);
`endif
      or_mode = 0;
      wait_done();

      // Back-pressure: output held 20 cycles while in_valid pulses are ignored.
      or_mode = 2;
      send(rnd_blk(0, 1'b0), rnd_blk(0, 1'b1), 1'b0);
      wait_ov(lat);
      for (int i = 0; i < 20; i++) begin
         if (i % 3 == 0) begin
            coef_in = rnd_blk(0, 1'b0);
            coeff_vector = rnd_blk(0, 1'b1);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         chk1("t4_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      or_mode = 0;
      wait_done();

      // Reset in the middle of COMP discards the block at once.
      send(rnd_blk(0, 1'b0), rnd_blk(0, 1'b1), 1'b0);
      repeat (29) @(negedge clk);
      chk_en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk1("t5_out_valid", out_valid, 1'b0);
      chk1("t5_in_ready", in_ready, 1'b1);
      blk_chk("t5_pix", pix_out, '0);
      chk1("t5_sat", sat_flag, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      inflight = 1'b0;
      chk_en = 1'b1;
      send(rnd_blk(0, 1'b0), rnd_blk(0, 1'b1), 1'b0);
      wait_done();

      // Streaming: four blocks back to back, one accept every 66 cycles.
      chain_chk = 1'b1;
      last_acc = -1;
      for (int b = 0; b < 4; b++) send(rnd_blk(0, 1'b0), rnd_blk(0, 1'b1), 1'b1);
      in_valid = 1'b0;
      wait_done();
      chain_chk = 1'b0;

      // Randomized traffic with random back-pressure and idle gaps.
      or_mode = 1;
      for (int b = 0; b < 8; b++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(rnd_blk(b % 2, 1'b0), rnd_blk(b % 2, 1'b1), 1'b0);
      end
      wait_done();
      or_mode = 0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
